// File: rtl/writeback_queue_if.sv
// writeback_queue_if
// Bundles the writeback queue's data-path signals: the execute-stage push
// handshake, the registered register-file write port, the two bypass lookup
// ports and the occupancy count. Clock and reset stay plain ports on the
// module.
//   master : producer/consumer side (drives in_*, fwd_addr*)
//   slave  : the queue itself (drives in_ready, enc/addrc/datac, fwd_hit*/fwd_data*, count)
// DEPTH must match the DEPTH of the writeback_queue it connects to.
interface writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;

    logic          enc;
    logic [4:0]    addrc;
    logic [31:0]   datac;

    logic [4:0]    fwd_addra;
    logic          fwd_hita;
    logic [31:0]   fwd_dataa;
    logic [4:0]    fwd_addrb;
    logic          fwd_hitb;
    logic [31:0]   fwd_datab;

    logic [CW-1:0] count;

    modport master (
        output in_valid, in_addr, in_data, fwd_addra, fwd_addrb,
        input  in_ready, enc, addrc, datac,
        input  fwd_hita, fwd_dataa, fwd_hitb, fwd_datab, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, fwd_addra, fwd_addrb,
        output in_ready, enc, addrc, datac,
        output fwd_hita, fwd_dataa, fwd_hitb, fwd_datab, count
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue
// Small FIFO between the execute stage and the register-file write port.
// Every edge with a non-empty queue pops the head into the registered write
// port (enc/addrc/datac), so the port sustains one write per cycle. Two
// combinational bypass ports search the queue plus the write-port register
// (when enc=1) for the youngest entry matching the lookup address.
//
// Ports
//   clock            : single clock, rising edge
//   reset            : synchronous, active-high; discards all pending entries
//   bus (slave)      : in_valid/in_ready/in_addr/in_data push side,
//                      enc/addrc/datac write port, fwd_* lookups, count
// Parameter
//   DEPTH            : entry count, power of two, 2..16
// Build option
//   WBQ_ZERO_FILTER_EN : when defined, pushes to address 0 complete the
//                        handshake but are dropped instead of enqueued
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input logic             clock,
    input logic             reset,
    writeback_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_enc;
    logic [4:0]    r_addrc;
    logic [31:0]   r_datac;

    logic          w_ready;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Readiness looks only at the current occupancy: a pop on the same edge
    // does not open a slot for a push when the queue is full.
    assign w_ready  = (r_count < CW'(DEPTH)) && !reset;
    assign w_accept = bus.in_valid && w_ready;
`ifdef WBQ_ZERO_FILTER_EN
    assign w_push   = w_accept && (bus.in_addr != 5'd0);
`else
    assign w_push   = w_accept;
`endif
    assign w_pop    = (r_count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_enc   <= 1'b0;
            r_addrc <= '0;
            r_datac <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr] <= bus.in_addr;
                r_data[r_wptr] <= bus.in_data;
                r_wptr         <= r_wptr + AW'(1);
            end
            r_enc <= w_pop;
            if (w_pop) begin
                r_addrc <= r_addr[r_rptr];
                r_datac <= r_data[r_rptr];
                r_rptr  <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    logic          w_hita;
    logic          w_hitb;
    logic [31:0]   w_dataa;
    logic [31:0]   w_datab;
    logic [AW-1:0] w_idx;

    // Candidates are visited oldest first (write-port register, then queue
    // from head to tail) so a later match overrides an earlier one and the
    // youngest entry wins.
    always_comb begin
        w_hita  = 1'b0;
        w_dataa = '0;
        w_hitb  = 1'b0;
        w_datab = '0;
        w_idx   = '0;
        if (r_enc) begin
            if (r_addrc == bus.fwd_addra) begin
                w_hita  = 1'b1;
                w_dataa = r_datac;
            end
            if (r_addrc == bus.fwd_addrb) begin
                w_hitb  = 1'b1;
                w_datab = r_datac;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + AW'(i);
            if (CW'(i) < r_count) begin
                if (r_addr[w_idx] == bus.fwd_addra) begin
                    w_hita  = 1'b1;
                    w_dataa = r_data[w_idx];
                end
                if (r_addr[w_idx] == bus.fwd_addrb) begin
                    w_hitb  = 1'b1;
                    w_datab = r_data[w_idx];
                end
            end
        end
        // Register 0 is hard-wired, so it is never bypassed.
        if (reset || bus.fwd_addra == 5'd0) begin
            w_hita  = 1'b0;
            w_dataa = '0;
        end
        if (reset || bus.fwd_addrb == 5'd0) begin
            w_hitb  = 1'b0;
            w_datab = '0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.enc       = r_enc;
    assign bus.addrc     = r_addrc;
    assign bus.datac     = r_datac;
    assign bus.fwd_hita  = w_hita;
    assign bus.fwd_dataa = w_dataa;
    assign bus.fwd_hitb  = w_hitb;
    assign bus.fwd_datab = w_datab;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
// Directed scenarios followed by a randomized run, all compared against a
// queue-based reference model of the writeback queue.
module tb_writeback_queue;
    localparam int DEPTH = 4;
`ifdef WBQ_ZERO_FILTER_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    writeback_queue_if #(.DEPTH(DEPTH)) bus();
    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_enc   = 1'b0;
    logic [4:0]  m_addrc = '0;
    logic [31:0] m_datac = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] got[$];
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest match first: newest queue entry back to oldest, then the
    // write-port register.
    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0 && !reset) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (!hit && m_q[i].a == a) begin
                    hit = 1'b1;
                    d   = m_q[i].d;
                end
            end
            if (!hit && m_enc && m_addrc == a) begin
                hit = 1'b1;
                d   = m_datac;
            end
        end
    endtask

    task automatic model_edge();
        bit   acc;
        ent_t e;
        if (reset) begin
            m_q.delete();
            m_enc   = 1'b0;
            m_addrc = '0;
            m_datac = '0;
        end else begin
            acc = bus.in_valid && (m_q.size() < DEPTH);
            if (m_q.size() > 0) begin
                e       = m_q.pop_front();
                m_enc   = 1'b1;
                m_addrc = e.a;
                m_datac = e.d;
            end else begin
                m_enc = 1'b0;
            end
            if (acc && !(ZF && bus.in_addr == 5'd0)) begin
                e.a = bus.in_addr;
                e.d = bus.in_data;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        logic        h;
        logic [31:0] d;
        chk("enc",      32'(bus.enc),      32'(m_enc));
        chk("addrc",    32'(bus.addrc),    32'(m_addrc));
        chk("datac",    bus.datac,         m_datac);
        chk("count",    32'(bus.count),    32'(m_q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(!reset && m_q.size() < DEPTH));
        model_fwd(bus.fwd_addra, h, d);
        chk("fwd_hita",  32'(bus.fwd_hita), 32'(h));
        chk("fwd_dataa", bus.fwd_dataa,     d);
        model_fwd(bus.fwd_addrb, h, d);
        chk("fwd_hitb",  32'(bus.fwd_hitb), 32'(h));
        chk("fwd_datab", bus.fwd_datab,     d);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_addr   = 5'd9;
        bus.in_data   = 32'd99;
        bus.fwd_addra = 5'd9;
        bus.fwd_addrb = 5'd0;
        reset         = 1'b1;

        // Reset held with a pending push.
        repeat (3) cycle();
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Latency from an empty queue.
        push(5'd31, 32'd3098);
        cycle();
        bus.in_valid = 1'b0;
        chk("lat_n_enc", 32'(bus.enc), 32'd0);
        cycle();
        chk("lat_n1_enc",   32'(bus.enc),   32'd1);
        chk("lat_n1_addrc", 32'(bus.addrc), 32'd31);
        chk("lat_n1_datac", bus.datac,      32'd3098);
        cycle();
        chk("lat_n2_enc", 32'(bus.enc), 32'd0);

        // Pushes offered during reset are ignored, then five in a row.
        reset = 1'b1;
        push(5'd1, 32'd10);
        repeat (4) cycle();
        reset = 1'b0;
        got.delete();
        for (int k = 1; k <= 5; k++) begin
            push(5'(k), 32'(k * 10));
            cycle();
            if (bus.enc) got.push_back(bus.datac);
        end
        bus.in_valid = 1'b0;
        repeat (6) begin
            cycle();
            if (bus.enc) got.push_back(bus.datac);
        end
        chk("seq_len", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("seq_data", got[k], 32'((k + 1) * 10));

        // Forwarding picks the youngest of two entries for the same address.
        push(5'd7, 32'd100);
        cycle();
        push(5'd7, 32'd200);
        cycle();
        bus.in_valid  = 1'b0;
        bus.fwd_addra = 5'd7;
        bus.fwd_addrb = 5'd8;
        #1;
        chk("fwd7_hit",  32'(bus.fwd_hita),  32'd1);
        chk("fwd7_data", bus.fwd_dataa,      32'd200);
        chk("fwd8_hit",  32'(bus.fwd_hitb),  32'd0);
        chk("fwd8_data", bus.fwd_datab,      32'd0);
        bus.fwd_addra = 5'd0;
        #1;
        chk("fwd0_hit", 32'(bus.fwd_hita), 32'd0);
        bus.fwd_addra = 5'd7;
        repeat (2) cycle();

        // Address-0 entries.
        bus.fwd_addra = 5'd0;
        got.delete();
        push(5'd0, 32'd9912);
        cycle();
        push(5'd31, 32'd9912);
        cycle();
        if (bus.enc) got.push_back(32'(bus.addrc));
        bus.in_valid = 1'b0;
        repeat (4) begin
            cycle();
            if (bus.enc) got.push_back(32'(bus.addrc));
        end
        chk("zero_pulses", 32'(got.size()), ZF ? 32'd1 : 32'd2);
        if (got.size() > 0) chk("zero_last_addr", got[got.size() - 1], 32'd31);

        // Reset while entries are still draining.
        push(5'd1, 32'd1);
        cycle();
        push(5'd2, 32'd2);
        cycle();
        push(5'd3, 32'd3);
        cycle();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        cycle();
        reset  = 1'b0;
        pulses = 0;
        repeat (3) begin
            cycle();
            if (bus.enc) pulses++;
        end
        chk("midrst_pulses", 32'(pulses), 32'd0);
        chk("midrst_count",  32'(bus.count), 32'd0);
        push(5'd12, 32'd5);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        chk("post_rst_enc",   32'(bus.enc),   32'd1);
        chk("post_rst_addrc", 32'(bus.addrc), 32'd12);
        chk("post_rst_datac", bus.datac,      32'd5);

        // Randomized traffic with a narrow address range to provoke hits.
        repeat (400) begin
            reset         = ($urandom_range(0, 39) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_addr   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
            bus.in_data   = $urandom;
            bus.fwd_addra = 5'($urandom_range(0, 7));
            bus.fwd_addrb = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
